// File: rtl/regfile_wb.sv
// Integer register file and writeback stage for the milano core.
// Two write ports (ALU and load return), two combinational read ports with
// write-through bypass, and a one-entry load scoreboard that stalls the
// issuing stage on RAW/WAW hazards against the outstanding load.
module regfile_wb #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic [DATA_W-1:0] rs1_rdata_o,
    output logic [DATA_W-1:0] rs2_rdata_o,
    input  logic              alu_rd_we_i,
    input  logic [ADDR_W-1:0] alu_rd_waddr_i,
    input  logic [DATA_W-1:0] alu_rd_wdata_i,
    input  logic              lsu_req_i,
    input  logic [ADDR_W-1:0] lsu_rd_addr_i,
    input  logic              lsu_rvalid_i,
    input  logic [DATA_W-1:0] lsu_rdata_i,
    output logic              stall_o,
    output logic              load_pending_o,
    output logic              collision_o
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } sb_state_t;

    sb_state_t         state_q;
    sb_state_t         state_d;
    logic [ADDR_W-1:0] pend_addr_q;
    logic [ADDR_W-1:0] pend_addr_d;
    logic              collision_q;

    logic [DATA_W-1:0] regs [NREG];

    logic              alu_we;
    logic              lsu_we;
    logic              collide;
    logic              alu_commit;

    // Qualified write enables; reset suppresses both ports so nothing
    // commits or bypasses during the reset cycle. x0 writes are discarded.
    always_comb begin
        alu_we     = alu_rd_we_i && !rst_i && (alu_rd_waddr_i != '0);
        lsu_we     = lsu_rvalid_i && !rst_i && (state_q == PENDING)
                     && (pend_addr_q != '0);
        collide    = alu_we && lsu_we && (alu_rd_waddr_i == pend_addr_q);
        alu_commit = alu_we && !collide;
    end

    // Read port 1: x0 reads zero, LSU bypass has priority over ALU bypass.
    always_comb begin
        rs1_rdata_o = regs[rs1_addr_i];
        if (rs1_addr_i == '0) begin
            rs1_rdata_o = '0;
        end else if (lsu_we && (pend_addr_q == rs1_addr_i)) begin
            rs1_rdata_o = lsu_rdata_i;
        end else if (alu_we && (alu_rd_waddr_i == rs1_addr_i)) begin
            rs1_rdata_o = alu_rd_wdata_i;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rs2_rdata_o = regs[rs2_addr_i];
        if (rs2_addr_i == '0) begin
            rs2_rdata_o = '0;
        end else if (lsu_we && (pend_addr_q == rs2_addr_i)) begin
            rs2_rdata_o = lsu_rdata_i;
        end else if (alu_we && (alu_rd_waddr_i == rs2_addr_i)) begin
            rs2_rdata_o = alu_rd_wdata_i;
        end
    end

    // Register array: cleared on reset, otherwise commit both ports; on a
    // same-address collision only the load data lands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (alu_commit) begin
                regs[alu_rd_waddr_i] <= alu_rd_wdata_i;
            end
            if (lsu_we) begin
                regs[pend_addr_q] <= lsu_rdata_i;
            end
        end
    end

    // Scoreboard next state: track one load; a request while still pending
    // without a return is a protocol violation and is ignored.
    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        case (state_q)
            IDLE: begin
                if (lsu_req_i && (lsu_rd_addr_i != '0)) begin
                    state_d     = PENDING;
                    pend_addr_d = lsu_rd_addr_i;
                end
            end
            PENDING: begin
                if (lsu_rvalid_i) begin
                    if (lsu_req_i && (lsu_rd_addr_i != '0)) begin
                        state_d     = PENDING;
                        pend_addr_d = lsu_rd_addr_i;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scoreboard state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    // One-cycle pulse after an ALU write was dropped in favour of the load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collide;
        end
    end

    // Hazard detect: the returning cycle never stalls since the bypass
    // supplies the load data; a disabled ALU write is not a WAW hazard.
    always_comb begin
        stall_o = 1'b0;
        if ((state_q == PENDING) && !lsu_rvalid_i && (pend_addr_q != '0)) begin
            stall_o = (rs1_addr_i == pend_addr_q)
                   || (rs2_addr_i == pend_addr_q)
                   || (alu_rd_we_i && (alu_rd_waddr_i == pend_addr_q));
        end
    end

    assign load_pending_o = (state_q == PENDING);
    assign collision_o    = collision_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: reset, x0, bypass, load hazard, collision,
// back-to-back loads and reset during an outstanding load.
module tb_regfile_wb;

    localparam int DATA_W = 32;
    localparam int NREG   = 32;
    localparam int ADDR_W = 5;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [ADDR_W-1:0] rs1_addr_i;
    logic [ADDR_W-1:0] rs2_addr_i;
    logic [DATA_W-1:0] rs1_rdata_o;
    logic [DATA_W-1:0] rs2_rdata_o;
    logic              alu_rd_we_i;
    logic [ADDR_W-1:0] alu_rd_waddr_i;
    logic [DATA_W-1:0] alu_rd_wdata_i;
    logic              lsu_req_i;
    logic [ADDR_W-1:0] lsu_rd_addr_i;
    logic              lsu_rvalid_i;
    logic [DATA_W-1:0] lsu_rdata_i;
    logic              stall_o;
    logic              load_pending_o;
    logic              collision_o;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rs1_addr_i     (rs1_addr_i),
        .rs2_addr_i     (rs2_addr_i),
        .rs1_rdata_o    (rs1_rdata_o),
        .rs2_rdata_o    (rs2_rdata_o),
        .alu_rd_we_i    (alu_rd_we_i),
        .alu_rd_waddr_i (alu_rd_waddr_i),
        .alu_rd_wdata_i (alu_rd_wdata_i),
        .lsu_req_i      (lsu_req_i),
        .lsu_rd_addr_i  (lsu_rd_addr_i),
        .lsu_rvalid_i   (lsu_rvalid_i),
        .lsu_rdata_i    (lsu_rdata_i),
        .stall_o        (stall_o),
        .load_pending_o (load_pending_o),
        .collision_o    (collision_o)
    );

    always #5 clk_i = ~clk_i;

    // Protocol checker: a new load must not issue while one is outstanding
    // unless the old one returns in the same cycle.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(load_pending_o && lsu_req_i && !lsu_rvalid_i))
            else $error("protocol violation: load issued while one is pending");
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        alu_rd_we_i    = 1'b0;
        alu_rd_waddr_i = '0;
        alu_rd_wdata_i = '0;
        lsu_req_i      = 1'b0;
        lsu_rd_addr_i  = '0;
        lsu_rvalid_i   = 1'b0;
        lsu_rdata_i    = '0;
        rs1_addr_i     = '0;
        rs2_addr_i     = '0;
    endtask

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_pending", {31'd0, load_pending_o}, 32'd0);
        chk("rst_collision", {31'd0, collision_o}, 32'd0);

        // Preload x1..x31, then reset and confirm everything reads zero.
        for (int i = 1; i < NREG; i++) begin
            alu_rd_we_i    = 1'b1;
            alu_rd_waddr_i = ADDR_W'(i);
            alu_rd_wdata_i = 32'h1000_0000 + 32'(i);
            tick();
        end
        alu_rd_we_i = 1'b0;
        rs1_addr_i  = 5'd17;
        #1;
        chk("preload_x17", rs1_rdata_o, 32'h1000_0011);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            rs1_addr_i = ADDR_W'(i);
            rs2_addr_i = ADDR_W'(NREG - 1 - i);
            #1;
            chk("rst_rs1", rs1_rdata_o, 32'd0);
            chk("rst_rs2", rs2_rdata_o, 32'd0);
        end
        chk("rst_stall2", {31'd0, stall_o}, 32'd0);

        // x0 is hardwired; x5 basic write.
        idle_inputs();
        alu_rd_we_i    = 1'b1;
        alu_rd_waddr_i = 5'd0;
        alu_rd_wdata_i = 32'hDEAD_BEEF;
        #1;
        chk("x0_bypass", rs1_rdata_o, 32'd0);
        tick();
        alu_rd_waddr_i = 5'd5;
        alu_rd_wdata_i = 32'h1234_5678;
        tick();
        alu_rd_we_i = 1'b0;
        rs1_addr_i  = 5'd0;
        rs2_addr_i  = 5'd5;
        #1;
        chk("x0_read", rs1_rdata_o, 32'd0);
        chk("x5_read", rs2_rdata_o, 32'h1234_5678);

        // Same-cycle write-through bypass.
        alu_rd_we_i    = 1'b1;
        alu_rd_waddr_i = 5'd7;
        alu_rd_wdata_i = 32'hA5A5_A5A5;
        rs1_addr_i     = 5'd7;
        #1;
        chk("bypass_x7", rs1_rdata_o, 32'hA5A5_A5A5);
        tick();
        alu_rd_we_i = 1'b0;
        #1;
        chk("x7_commit", rs1_rdata_o, 32'hA5A5_A5A5);

        // Load hazard on x9.
        idle_inputs();
        lsu_req_i     = 1'b1;
        lsu_rd_addr_i = 5'd9;
        tick();
        lsu_req_i  = 1'b0;
        rs2_addr_i = 5'd9;
        chk("ld_pending", {31'd0, load_pending_o}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("ld_raw_stall", {31'd0, stall_o}, 32'd1);
            tick();
        end
        rs2_addr_i     = 5'd0;
        alu_rd_waddr_i = 5'd9;
        #1;
        chk("ld_we_off_nostall", {31'd0, stall_o}, 32'd0);
        alu_rd_we_i    = 1'b1;
        alu_rd_wdata_i = 32'h0000_0777;
        #1;
        chk("ld_waw_stall", {31'd0, stall_o}, 32'd1);
        tick();
        alu_rd_we_i  = 1'b0;
        rs2_addr_i   = 5'd9;
        lsu_rvalid_i = 1'b1;
        lsu_rdata_i  = 32'h0000_0042;
        #1;
        chk("ld_rvalid_stall", {31'd0, stall_o}, 32'd0);
        chk("ld_rvalid_bypass", rs2_rdata_o, 32'h0000_0042);
        chk("ld_pending_hold", {31'd0, load_pending_o}, 32'd1);
        tick();
        lsu_rvalid_i = 1'b0;
        #1;
        chk("ld_pending_fall", {31'd0, load_pending_o}, 32'd0);
        chk("ld_x9_commit", rs2_rdata_o, 32'h0000_0042);
        chk("ld_idle_stall", {31'd0, stall_o}, 32'd0);

        // Collision on x3: load data wins, one-cycle pulse.
        idle_inputs();
        lsu_req_i     = 1'b1;
        lsu_rd_addr_i = 5'd3;
        tick();
        lsu_req_i      = 1'b0;
        alu_rd_we_i    = 1'b1;
        alu_rd_waddr_i = 5'd3;
        alu_rd_wdata_i = 32'h0000_0001;
        lsu_rvalid_i   = 1'b1;
        lsu_rdata_i    = 32'h0000_0002;
        rs1_addr_i     = 5'd3;
        #1;
        chk("col_bypass", rs1_rdata_o, 32'h0000_0002);
        chk("col_pre", {31'd0, collision_o}, 32'd0);
        tick();
        alu_rd_we_i  = 1'b0;
        lsu_rvalid_i = 1'b0;
        #1;
        chk("col_pulse", {31'd0, collision_o}, 32'd1);
        chk("col_x3", rs1_rdata_o, 32'h0000_0002);
        tick();
        chk("col_pulse_end", {31'd0, collision_o}, 32'd0);

        // ALU and LSU to different addresses: both commit, no collision.
        idle_inputs();
        lsu_req_i     = 1'b1;
        lsu_rd_addr_i = 5'd10;
        tick();
        lsu_req_i      = 1'b0;
        alu_rd_we_i    = 1'b1;
        alu_rd_waddr_i = 5'd11;
        alu_rd_wdata_i = 32'h0000_00BB;
        lsu_rvalid_i   = 1'b1;
        lsu_rdata_i    = 32'h0000_00AA;
        tick();
        idle_inputs();
        rs1_addr_i = 5'd10;
        rs2_addr_i = 5'd11;
        #1;
        chk("dual_x10", rs1_rdata_o, 32'h0000_00AA);
        chk("dual_x11", rs2_rdata_o, 32'h0000_00BB);
        chk("dual_nocol", {31'd0, collision_o}, 32'd0);

        // rvalid while idle writes nothing.
        lsu_rvalid_i = 1'b1;
        lsu_rdata_i  = 32'hFFFF_0000;
        #1;
        chk("idle_rvalid_bypass", rs1_rdata_o, 32'h0000_00AA);
        tick();
        lsu_rvalid_i = 1'b0;
        #1;
        chk("idle_rvalid_x10", rs1_rdata_o, 32'h0000_00AA);

        // Load to x0 is untracked.
        lsu_req_i     = 1'b1;
        lsu_rd_addr_i = 5'd0;
        tick();
        lsu_req_i = 1'b0;
        chk("ldx0_idle", {31'd0, load_pending_o}, 32'd0);

        // Back-to-back loads: x4 returns while x6 issues.
        idle_inputs();
        lsu_req_i     = 1'b1;
        lsu_rd_addr_i = 5'd4;
        tick();
        lsu_rvalid_i  = 1'b1;
        lsu_rdata_i   = 32'h0000_0044;
        lsu_rd_addr_i = 5'd6;
        rs1_addr_i    = 5'd4;
        #1;
        chk("b2b_bypass_x4", rs1_rdata_o, 32'h0000_0044);
        tick();
        lsu_req_i    = 1'b0;
        lsu_rvalid_i = 1'b0;
        #1;
        chk("b2b_pending", {31'd0, load_pending_o}, 32'd1);
        chk("b2b_x4", rs1_rdata_o, 32'h0000_0044);
        rs1_addr_i = 5'd6;
        #1;
        chk("b2b_stall_x6", {31'd0, stall_o}, 32'd1);

        // Reset mid-load: scoreboard drops x6, later return is ignored.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        chk("midrst_pending", {31'd0, load_pending_o}, 32'd0);
        chk("midrst_stall", {31'd0, stall_o}, 32'd0);
        lsu_rvalid_i = 1'b1;
        lsu_rdata_i  = 32'h0000_0066;
        #1;
        chk("midrst_bypass_x6", rs1_rdata_o, 32'd0);
        tick();
        lsu_rvalid_i = 1'b0;
        #1;
        chk("midrst_x6", rs1_rdata_o, 32'd0);
        rs1_addr_i = 5'd4;
        #1;
        chk("midrst_x4", rs1_rdata_o, 32'd0);

        // Back-to-back where the second load targets x0: drop to IDLE.
        idle_inputs();
        lsu_req_i     = 1'b1;
        lsu_rd_addr_i = 5'd8;
        tick();
        lsu_rvalid_i  = 1'b1;
        lsu_rdata_i   = 32'h0000_0088;
        lsu_rd_addr_i = 5'd0;
        tick();
        idle_inputs();
        rs2_addr_i = 5'd8;
        #1;
        chk("b2b_x0_idle", {31'd0, load_pending_o}, 32'd0);
        chk("b2b_x0_x8", rs2_rdata_o, 32'h0000_0088);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
